// File: rtl/instr_exec_pkg.sv
// Shared definitions for the instr_exec decode/execute slice.
// Holds the datapath width, default sizes, opcode values, instruction
// field positions and the immediate sign-extension helpers.
package instr_exec_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int DMEM_DEPTH = 32;

  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_SW   = 7'b1100111;

  // Field positions (LSB of each field) within a 32-bit instruction.
  localparam int OPC_LSB    = 0;
  localparam int RD_LSB     = 7;
  localparam int F3_LSB     = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int IMMS_H_LSB = 25;

  // I-type immediate: instr[31:20], sign-extended.
  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{(XLEN-12){instr[31]}}, instr[31:20]};
  endfunction

  // S-type immediate: {instr[31:25], instr[11:7]}, sign-extended.
  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] instr);
    return {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

endpackage

// File: rtl/instr_exec_regfile.sv
// Architectural register file for instr_exec.
// Two combinational read ports, one synchronous write port.
// x0 always reads as zero and ignores writes; reset loads each register
// with its own index (x1=1, x2=2, ...).
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   ra1/rd1         read port 1 address / data
//   ra2/rd2         read port 2 address / data
//   we, wa, wd      write enable, address, data (takes effect at the edge)
module instr_exec_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RAW  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RAW-1:0]  ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [RAW-1:0]  ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [RAW-1:0]  wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= XLEN'(i);
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see pre-edge state, so a same-cycle write returns the old value.
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/instr_exec.sv
// Single-cycle decode/execute core for an ADDI + SW instruction subset.
// One instruction is consumed every clock; there is no handshake: holding
// instr constant re-executes it each cycle.
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous active-high reset (beats any instruction)
//   instr    instruction executed this cycle
//   showout  debug display enable for regout/memout
//   regout   value of the last register write seen while showout=1
//   memout   data of the last store seen while showout=1
module instr_exec #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int DMEM_DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic            showout,
  output logic [XLEN-1:0] regout,
  output logic [XLEN-1:0] memout
);
  import instr_exec_pkg::*;

  localparam int AW = $clog2(DMEM_DEPTH);

  // Field decode
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic            is_addi, is_sw, reg_we;
  logic [XLEN-1:0] rs1_val, rs2_val, addi_res, st_sum;
  logic [AW-1:0]   st_addr;
  logic            unused_bits;

  assign opcode = instr[OPC_LSB +: 7];
  assign rd     = instr[RD_LSB  +: 5];
  assign funct3 = instr[F3_LSB  +: 3];
  assign rs1    = instr[RS1_LSB +: 5];
  assign rs2    = instr[RS2_LSB +: 5];

  assign is_addi = (opcode == OPC_ADDI);
  assign is_sw   = (opcode == OPC_SW);
  // ADDI to x0 is architecturally a no-op, including for regout.
  assign reg_we  = is_addi && (rd != 5'd0);

  instr_exec_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .rd1 (rs1_val),
    .ra2 (rs2),
    .rd2 (rs2_val),
    .we  (reg_we),
    .wa  (rd),
    .wd  (addi_res)
  );

  assign addi_res = rs1_val + imm_i(instr);
  // Store address wraps: only the low AW bits of the sum index dmem.
  assign st_sum   = rs1_val + imm_s(instr);
  assign st_addr  = st_sum[AW-1:0];

  // funct3 is ignored by both instructions; upper sum bits are discarded.
  assign unused_bits = ^{funct3, st_sum[XLEN-1:AW]};

  logic [XLEN-1:0] dmem [DMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        dmem[i] <= '0;
      end
      regout <= '0;
      memout <= '0;
    end else begin
      if (is_sw) begin
        dmem[st_addr] <= rs2_val;
      end
      if (showout) begin
        if (reg_we) regout <= addi_res;
        if (is_sw)  memout <= rs2_val;
      end
    end
  end

endmodule

// File: tb/tb_instr_exec.sv
module tb_instr_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        showout;
  logic [31:0] regout, memout;

  int n_vec = 0;
  int n_bad = 0;

  // Reference architectural state
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [32];
  logic [31:0] m_regout, m_memout;

  always #5 clk = ~clk;

  instr_exec dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .showout (showout),
    .regout  (regout),
    .memout  (memout)
  );

  function automatic logic [31:0] enc_addi(int rd_i, int rs1_i, int imm);
    logic [11:0] im;
    im = imm[11:0];
    return {im, 5'(rs1_i), 3'b110, 5'(rd_i), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_sw(int rs1_i, int rs2_i, int imm);
    logic [11:0] im;
    im = imm[11:0];
    return {im[11:5], 5'(rs2_i), 5'(rs1_i), 3'b111, im[4:0], 7'b1100111};
  endfunction

  // Behavioural model: one instruction's effect on the architectural state.
  task automatic model_step(input logic [31:0] ins, input logic sh, input logic r);
    logic signed [11:0] ii, is;
    logic [31:0] a, b, res;
    int addr;
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'(i);
        m_dmem[i] = '0;
      end
      m_regout = '0;
      m_memout = '0;
    end else begin
      ii = ins[31:20];
      is = {ins[31:25], ins[11:7]};
      a  = m_regs[ins[19:15]];
      b  = m_regs[ins[24:20]];
      if (ins[6:0] == 7'b0010011) begin
        res = a + 32'(ii);
        if (ins[11:7] != 0) begin
          m_regs[ins[11:7]] = res;
          if (sh) m_regout = res;
        end
      end else if (ins[6:0] == 7'b1100111) begin
        res  = a + 32'(is);
        addr = int'(res % 32);
        m_dmem[addr] = b;
        if (sh) m_memout = b;
      end
    end
  endtask

  task automatic apply(input logic [31:0] ins, input logic sh, input logic r);
    instr   = ins;
    showout = sh;
    rst     = r;
    @(posedge clk);
    model_step(ins, sh, r);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        sh;
    logic        r;
    logic [31:0] exp_reg;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{enc_addi(2, 1, 3),    1'b1, 1'b0, 32'd4,  32'd0};
    tbl[1]  = '{enc_sw(2, 1, 3),      1'b1, 1'b0, 32'd4,  32'd1};
    tbl[2]  = '{enc_addi(0, 1, 5),    1'b1, 1'b0, 32'd4,  32'd1};
    tbl[3]  = '{enc_addi(3, 1, -1),   1'b1, 1'b0, 32'd0,  32'd1};
    tbl[4]  = '{enc_addi(4, 1, 7),    1'b0, 1'b0, 32'd0,  32'd1};
    tbl[5]  = '{enc_addi(4, 1, 7),    1'b1, 1'b0, 32'd8,  32'd1};
    tbl[6]  = '{enc_addi(5, 2, 0),    1'b1, 1'b0, 32'd4,  32'd1};
    tbl[7]  = '{enc_sw(4, 6, 27),     1'b1, 1'b0, 32'd4,  32'd6};
    tbl[8]  = '{enc_addi(7, 0, 9),    1'b1, 1'b0, 32'd9,  32'd6};
    tbl[9]  = '{enc_addi(8, 1, 100),  1'b1, 1'b1, 32'd0,  32'd0};
    tbl[10] = '{enc_addi(9, 4, 0),    1'b1, 1'b0, 32'd4,  32'd0};
    tbl[11] = '{enc_addi(10, 8, 0),   1'b1, 1'b0, 32'd8,  32'd0};
    tbl[12] = '{32'h0000_0000,        1'b1, 1'b0, 32'd8,  32'd0};
    tbl[13] = '{enc_addi(11, 11, 1),  1'b1, 1'b0, 32'd12, 32'd0};
    tbl[14] = '{enc_addi(11, 11, 1),  1'b1, 1'b0, 32'd13, 32'd0};
    tbl[15] = '{enc_sw(0, 3, -1),     1'b0, 1'b0, 32'd13, 32'd0};

    // Reset
    apply(32'h0, 1'b1, 1'b1);
    apply(enc_addi(1, 1, 50), 1'b1, 1'b1);
    check("reset_regout", regout, 32'd0);
    check("reset_memout", memout, 32'd0);
    for (int k = 0; k < 32; k++) check($sformatf("reset_dmem[%0d]", k), dut.dmem[k], 32'd0);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].ins, tbl[i].sh, tbl[i].r);
      check($sformatf("tbl%0d_regout", i), regout, tbl[i].exp_reg);
      check($sformatf("tbl%0d_memout", i), memout, tbl[i].exp_mem);
      case (i)
        1:  check("sw_dmem7", dut.dmem[7], 32'd1);
        7:  check("sw_wrap_dmem3", dut.dmem[3], 32'd6);
        9:  begin
              check("midreset_dmem7", dut.dmem[7], 32'd0);
              check("midreset_dmem3", dut.dmem[3], 32'd0);
            end
        15: check("sw_neg_dmem31", dut.dmem[31], 32'd3);
        default: ;
      endcase
    end

    // Randomized stimulus against the model
    for (int n = 0; n < 800; n++) begin
      logic [31:0] ins;
      logic        sh, r;
      int          sel;
      ins = $urandom;
      sel = $urandom_range(0, 9);
      if (sel <= 4)      ins[6:0] = 7'b0010011;
      else if (sel <= 7) ins[6:0] = 7'b1100111;
      sh = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 59) == 0);
      apply(ins, sh, r);
      check($sformatf("rand%0d_regout", n), regout, m_regout);
      check($sformatf("rand%0d_memout", n), memout, m_memout);
    end

    // Final memory image against the model
    for (int k = 0; k < 32; k++) check($sformatf("final_dmem[%0d]", k), dut.dmem[k], m_dmem[k]);

    // Final register image, read out through ADDI rd, rs, 0 into regout
    for (int k = 1; k < 31; k++) begin
      logic [31:0] want;
      want = m_regs[k];
      apply(enc_addi(31, k, 0), 1'b1, 1'b0);
      check($sformatf("final_x%0d", k), regout, want);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
